// File: rtl/judge_scheduler.sv
// Shares one judge unit between the red and blue note lanes: captures presses and misses
// per lane, grants round-robin, issues judge requests and reports lane-tagged scores.
module judge_scheduler #(
   parameter int COOLDOWN    = 4,
   parameter int MISS_OFFSET = 6,
   parameter int TIMEOUT     = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       red_button,
   input  logic       blue_button,
   input  logic       node_R,
   input  logic       node_B,
   input  logic [2:0] offset,
   output logic       jreq,
   output logic       jlane,
   output logic [2:0] joffset,
   input  logic       jdone,
   input  logic [1:0] jscore,
   output logic       score_valid,
   output logic [1:0] score,
   output logic       score_lane,
   output logic       delete_R,
   output logic       delete_B,
   output logic       busy
);

   localparam int CW = $clog2(COOLDOWN + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] COOL_INIT = CW'(COOLDOWN);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [2:0]    MISS_OFF  = 3'(MISS_OFFSET);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, REPORT} state_t;

   state_t        state_q, state_d;
   logic [1:0]    pend_q, pend_d;
   logic [1:0]    miss_q, miss_d;
   logic [2:0]    poff_q [2];
   logic [2:0]    poff_d [2];
   logic [CW-1:0] cool_q [2];
   logic [CW-1:0] cool_d [2];
   logic [TW-1:0] tmo_q, tmo_d;
   logic          glane_q, glane_d;
   logic [2:0]    goff_q, goff_d;
   logic [1:0]    gscore_q, gscore_d;
   logic          last_q, last_d;

   logic [1:0]    button;
   logic [1:0]    node;
   logic [1:0]    accept;
   logic [1:0]    miss_cap;
   logic          grant_lane;

   assign button = {blue_button, red_button};
   assign node   = {node_B, node_R};

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      miss_d     = miss_q;
      poff_d     = poff_q;
      cool_d     = cool_q;
      tmo_d      = tmo_q;
      glane_d    = glane_q;
      goff_d     = goff_q;
      gscore_d   = gscore_q;
      last_d     = last_q;
      grant_lane = 1'b0;
      accept     = '0;
      miss_cap   = '0;

      case (state_q)
         IDLE: begin
            if (pend_q != 2'b00) begin
               grant_lane         = (pend_q == 2'b11) ? ~last_q : pend_q[1];
               glane_d            = grant_lane;
               goff_d             = poff_q[grant_lane];
               gscore_d           = 2'b00;
               last_d             = grant_lane;
               pend_d[grant_lane] = 1'b0;
               tmo_d              = '0;
               state_d            = miss_q[grant_lane] ? REPORT : ISSUE;
            end
         end
         ISSUE: begin
            tmo_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (jdone) begin
               gscore_d = jscore;
               state_d  = REPORT;
            end else if (tmo_q == TMO_LAST) begin
               gscore_d = 2'b00;
               state_d  = REPORT;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         REPORT: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Lane capture runs after the grant so a new event overrides the grant's clear.
      for (int i = 0; i < 2; i++) begin
         accept[i]   = button[i] & node[i] & ~pend_q[i] & (cool_q[i] == '0);
         miss_cap[i] = node[i] & (offset == MISS_OFF) & ~pend_q[i] & ~accept[i];
         if (accept[i]) begin
            pend_d[i] = 1'b1;
            miss_d[i] = 1'b0;
            poff_d[i] = offset;
            cool_d[i] = COOL_INIT;
         end else begin
            if (cool_q[i] != '0) begin
               cool_d[i] = cool_q[i] - CW'(1);
            end
            if (miss_cap[i]) begin
               pend_d[i] = 1'b1;
               miss_d[i] = 1'b1;
               poff_d[i] = offset;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pend_q    <= '0;
         miss_q    <= '0;
         poff_q[0] <= '0;
         poff_q[1] <= '0;
         cool_q[0] <= '0;
         cool_q[1] <= '0;
         tmo_q     <= '0;
         glane_q   <= 1'b0;
         goff_q    <= '0;
         gscore_q  <= '0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         miss_q    <= miss_d;
         poff_q    <= poff_d;
         cool_q    <= cool_d;
         tmo_q     <= tmo_d;
         glane_q   <= glane_d;
         goff_q    <= goff_d;
         gscore_q  <= gscore_d;
         last_q    <= last_d;
      end
   end

   // Outputs are gated by state so everything idles at zero.
   always_comb begin
      jreq        = (state_q == ISSUE);
      jlane       = jreq & glane_q;
      joffset     = jreq ? goff_q : 3'b000;
      score_valid = (state_q == REPORT);
      score       = score_valid ? gscore_q : 2'b00;
      score_lane  = score_valid & glane_q;
      delete_R    = score_valid & ~glane_q;
      delete_B    = score_valid & glane_q;
      busy        = (state_q != IDLE);
   end

endmodule

// File: tb/tb_judge_scheduler.sv
// Bench for judge_scheduler: directed scenarios then random traffic, all checked every cycle
// against a job-timeline model (grant edge, report period) of the scheduler.
module tb_judge_scheduler;

   localparam int COOLDOWN    = 4;
   localparam int MISS_OFFSET = 6;
   localparam int TIMEOUT     = 15;

   logic       clk = 1'b0;
   logic       rst, red_button, blue_button, node_R, node_B, jdone;
   logic [2:0] offset;
   logic [1:0] jscore;
   logic       jreq, jlane, score_valid, score_lane, delete_R, delete_B, busy;
   logic [2:0] joffset;
   logic [1:0] score;

   always #5 clk = ~clk;

   judge_scheduler #(
      .COOLDOWN(COOLDOWN), .MISS_OFFSET(MISS_OFFSET), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .red_button(red_button), .blue_button(blue_button),
      .node_R(node_R), .node_B(node_B), .offset(offset), .jreq(jreq), .jlane(jlane),
      .joffset(joffset), .jdone(jdone), .jscore(jscore), .score_valid(score_valid),
      .score(score), .score_lane(score_lane), .delete_R(delete_R), .delete_B(delete_B),
      .busy(busy)
   );

   int passed = 0;
   int total  = 0;
   int edge_n = 0;

   // Lane bookkeeping plus the single job currently owned by the judge path.
   bit m_pend [2];
   bit m_miss [2];
   int m_poff [2];
   int m_cool [2];
   int m_last = 1;
   bit job_valid = 0;
   bit job_miss;
   int job_lane, job_off, job_g, job_r, job_d, job_sc;
   int idle_from = 0;
   bit rand_mode = 0;
   int plan_d = 0;
   int plan_sc = 3;

   task automatic modelEdge();
      bit btn [2];
      bit nd [2];
      bit acc [2];
      bit mc [2];
      int lane;
      btn[0] = red_button;  btn[1] = blue_button;
      nd[0]  = node_R;      nd[1]  = node_B;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_miss[i] = 0; m_poff[i] = 0; m_cool[i] = 0;
         end
         m_last    = 1;
         job_valid = 0;
         idle_from = edge_n;
      end else begin
         for (int i = 0; i < 2; i++) begin
            acc[i] = btn[i] && nd[i] && !m_pend[i] && (m_cool[i] == 0);
            mc[i]  = nd[i] && (int'(offset) == MISS_OFFSET) && !m_pend[i] && !acc[i];
         end
         if ((edge_n - 1 >= idle_from) && (m_pend[0] || m_pend[1])) begin
            lane = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[1] ? 1 : 0);
            if (rand_mode) begin
               plan_d  = ($urandom_range(0, 4) == 0) ? TIMEOUT + int'($urandom_range(0, 2))
                                                     : int'($urandom_range(0, TIMEOUT - 1));
               plan_sc = int'($urandom_range(0, 3));
            end
            job_valid = 1;
            job_lane  = lane;
            job_miss  = m_miss[lane];
            job_off   = m_poff[lane];
            job_g     = edge_n;
            job_d     = plan_d;
            if (job_miss) begin
               job_r = edge_n;               job_sc = 0;
            end else if (plan_d < TIMEOUT) begin
               job_r = edge_n + 2 + plan_d;  job_sc = plan_sc;
            end else begin
               job_r = edge_n + 1 + TIMEOUT; job_sc = 0;
            end
            idle_from    = job_r + 1;
            m_last       = lane;
            m_pend[lane] = 0;
         end
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               m_pend[i] = 1; m_miss[i] = 0; m_poff[i] = int'(offset); m_cool[i] = COOLDOWN;
            end else begin
               if (m_cool[i] > 0) m_cool[i]--;
               if (mc[i]) begin
                  m_pend[i] = 1; m_miss[i] = 1; m_poff[i] = int'(offset);
               end
            end
         end
      end
   endtask

   task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, obs, expv);
   endtask

   task automatic checkOutput();
      bit in_job, e_jreq, e_sv;
      int e_lane, e_off, e_score;
      in_job  = job_valid && (edge_n >= job_g) && (edge_n <= job_r);
      e_jreq  = job_valid && !job_miss && (edge_n == job_g);
      e_sv    = job_valid && (edge_n == job_r);
      e_lane  = (e_jreq || e_sv) ? job_lane : 0;
      e_off   = e_jreq ? job_off : 0;
      e_score = e_sv ? job_sc : 0;
      checkOne("busy",        {3'b0, busy},        4'(in_job));
      checkOne("jreq",        {3'b0, jreq},        4'(e_jreq));
      checkOne("jlane",       {3'b0, jlane},       4'(e_jreq ? e_lane : 0));
      checkOne("joffset",     {1'b0, joffset},     4'(e_off));
      checkOne("score_valid", {3'b0, score_valid}, 4'(e_sv));
      checkOne("score",       {2'b0, score},       4'(e_score));
      checkOne("score_lane",  {3'b0, score_lane},  4'(e_sv ? e_lane : 0));
      checkOne("delete_R",    {3'b0, delete_R},    4'(e_sv && e_lane == 0));
      checkOne("delete_B",    {3'b0, delete_B},    4'(e_sv && e_lane == 1));
   endtask

   // One clock: drive inputs, let the model see the same edge, check mid-cycle.
   task automatic applyStimulus(input bit r, input bit rb, input bit bb, input bit nr,
                                input bit nb, input int off, input int force_jd);
      bit wait_win;
      rst         = r;
      red_button  = rb;
      blue_button = bb;
      node_R      = nr;
      node_B      = nb;
      offset      = 3'(off);
      wait_win    = job_valid && !job_miss && (edge_n >= job_g + 1) && (edge_n < job_r);
      if (force_jd >= 0) begin
         jdone  = force_jd[0];
         jscore = 2'($urandom_range(0, 3));
      end else if (wait_win) begin
         jdone  = (job_d < TIMEOUT) && (edge_n == job_g + 1 + job_d);
         jscore = jdone ? 2'(job_sc) : 2'($urandom_range(0, 3));
      end else begin
         jdone  = ($urandom_range(0, 3) == 0);
         jscore = 2'($urandom_range(0, 3));
      end
      @(posedge clk);
      edge_n++;
      modelEdge();
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, -1);
   endtask

   initial begin
      rst = 1'b1; red_button = 1'b0; blue_button = 1'b0; node_R = 1'b0; node_B = 1'b0;
      offset = 3'd0; jdone = 1'b0; jscore = 2'b00;

      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);

      // Red press at offset 3, judge answers perfect in the first WAIT cycle.
      plan_d = 0; plan_sc = 3;
      applyStimulus(0, 1, 0, 1, 0, 3, -1);
      idleCycles(6);

      // Tie, then a reset and the same tie again.
      plan_d = 0; plan_sc = 2;
      applyStimulus(0, 1, 1, 1, 1, 2, -1);
      idleCycles(10);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 1, 1, 5, -1);
      idleCycles(10);

      // Press without a note, then a press inside the cooldown, then one after it.
      plan_d = 1; plan_sc = 1;
      applyStimulus(0, 1, 0, 0, 0, 4, -1);
      idleCycles(2);
      applyStimulus(0, 1, 0, 1, 0, 2, -1);
      idleCycles(1);
      applyStimulus(0, 1, 0, 1, 0, 5, -1);
      idleCycles(8);
      applyStimulus(0, 1, 0, 1, 0, 7, -1);
      idleCycles(8);

      // Blue note reaches the miss offset unpressed.
      applyStimulus(0, 0, 0, 0, 1, MISS_OFFSET, -1);
      idleCycles(5);

      // Judge never answers.
      plan_d = TIMEOUT + 1;
      applyStimulus(0, 0, 1, 0, 1, 1, -1);
      idleCycles(TIMEOUT + 6);

      // Reset while waiting on the judge, then a late jdone.
      applyStimulus(0, 1, 0, 1, 0, 4, -1);
      idleCycles(4);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      idleCycles(3);

      rand_mode = 1;
      for (int i = 0; i < 800; i++) begin
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       int'($urandom_range(0, 7)), -1);
      end
      idleCycles(TIMEOUT + 6);

      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
